uart_rx_mmio: RTL
=================

# uart_rx_mmio

Memory-mapped UART receiver, the receive-side counterpart of the CPU's UART transmit path. It deserializes 8N1 frames from the RXD pin using 16x oversampling and buffers received bytes in a small FIFO. It exposes a DATA/STATUS register pair on a read-only MMIO port that the CPU polls, or waits on via `irq`. It sits in `top` beside `cpu_top`, with `rxd` wired to the board RXD pin.

## Interface
- `CLK_FREQ`, default 50_000_000: system clock frequency in Hz.
- `BAUD`, default 115200: line rate; tick divider `DIV = CLK_FREQ/(BAUD*16)`, must be ≥1 (elaboration error otherwise).
- `FIFO_DEPTH`, default 4: receive FIFO entries, power of two, ≥2.
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `rxd` in 1: serial input, asynchronous to `clk`, idle high.
- `addr` in 1: 0 = DATA, 1 = STATUS.
- `rd` in 1: read strobe, one cycle per access.
- `rd_data` out 16: read result, valid the cycle after `rd`; holds value until next `rd`.
- `irq` out 1: high while FIFO non-empty.

## Operation
- `rxd` passes a 2-flop synchronizer; reset value 1.
- Tick generator: counter 0..DIV-1; one-cycle `tick` on wrap. The counter runs freely.
- FSM states:
  - IDLE: on synchronized `rxd`=0 → START; clear the oversample count.
  - START: at the 8th tick, re-sample; 0 → DATA (bit index 0), 1 → IDLE (glitch rejected, nothing recorded).
  - DATA: every 16 ticks, sample into shift register LSB first; after bit 7 → STOP (or PARITY if enabled).
  - STOP: at 16 ticks, sample. 1 → push byte. 0 → set `frame_err`, discard byte. Always → IDLE.
- Push when FIFO full: byte dropped, `overrun` set, FIFO unchanged.
- DATA read (`addr`=0): `rd_data = {8'h00, byte}` and pops. If empty: `rd_data = 16'h0000`, no state change.
- STATUS read (`addr`=1): `rd_data = {8'h00, parity_err, frame_err, overrun, count[4:0]}`. Bit 7 is `parity_err`, bit 6 `frame_err`, bit 5 `overrun`, bits 4:0 FIFO count. Reading STATUS clears the three sticky flags. An error event in the same cycle as a STATUS read wins: its flag stays set.
- Push and pop in the same cycle: both occur, including when full (count unchanged, no overrun).
- Reset mid-frame: FSM → IDLE, FIFO emptied, flags cleared. A partial frame is lost. Reception resumes on the next falling edge after reset release.
- Reset values: `rd_data` = 0, `irq` = 0, count = 0, all flags 0, FSM IDLE.

## Timing
- Start-edge detect latency: 2 cycles (synchronizer).
- Start sampled at 8 ticks after detect; data bit n sampled at (8+16·(n+1)) ticks; stop at 8+16·9 ticks.
- Byte visible: `irq` rises 1 cycle after the stop-bit sample; COUNT increments in the same cycle.
- Read latency: exactly 1 cycle from `rd` to `rd_data`; pop takes effect at that same edge.
- Back-to-back frames: IDLE is re-entered mid-stop-bit, so a start edge half a bit after the stop sample is accepted.

## Configuration
- `UART_RX_PARITY_EN` defined: frame is 8E1. PARITY state samples the 9th bit 16 ticks after bit 7. On even-parity mismatch, `parity_err` is set and the byte is still pushed.
- Undefined: 8N1, no PARITY state; STATUS bit 7 reads 0.

## Structure
- Package `uart_pkg`: FSM state enum (IDLE, START, DATA, PARITY, STOP), `ADDR_DATA`/`ADDR_STATUS` constants, STATUS bit-position constants, `OVERSAMPLE = 16`.
- Sub-module `rx_fifo`: synchronous FIFO with parameters WIDTH and DEPTH. Ports: push, pop, din, dout, count, full, empty. Pop-before-push semantics when full.

## Test plan
Bench: CLK_FREQ=16_000_000, BAUD=1_000_000 (DIV=1, 16 clk/bit).
- Send 0xA5 8N1 → `irq`=1; STATUS read = 0x0001; DATA read = 0x00A5; `irq`=0 the cycle after.
- 50-cycle... rather, a 5-clock low glitch on `rxd` → no push; STATUS = 0x0000.
- Send 0x3C with stop bit driven 0 → STATUS = 0x0040; second STATUS read = 0x0000; FIFO empty.
- Send 5 bytes 0x01..0x05 without reading (depth 4) → STATUS = 0x0024; DATA reads return 0x01..0x04, then 0x0000.
- Assert `rst_n`=0 during bit 3 of a frame, release, then send 0x7E → only 0x7E received, count = 1.
- With `UART_RX_PARITY_EN`: send 0x07 with parity bit 0 (wrong) → STATUS = 0x0081; DATA = 0x0007.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART receiver: FSM state
// encoding, register addresses, STATUS bit positions and oversampling.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam logic ADDR_DATA   = 1'b0;
  localparam logic ADDR_STATUS = 1'b1;

  localparam int STAT_PARITY_BIT  = 7;
  localparam int STAT_FRAME_BIT   = 6;
  localparam int STAT_OVERRUN_BIT = 5;

  localparam int OVERSAMPLE = 16;

  // Oversample count values at which the line is sampled: mid start bit,
  // and one full bit period for data, parity and stop bits.
  localparam logic [3:0] MID_TICK  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);

endpackage

// File: rtl/rx_fifo.sv
// Small synchronous FIFO for received bytes. A pop and a push in the same
// cycle both take effect even when full (pop frees the slot first).
module rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW + 1)'(1);
      else if (do_pop && !do_push) count <= count - (AW + 1)'(1);
    end
  end

  // Storage write; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/uart_rx_mmio.sv
// Memory-mapped UART receiver: 16x oversampled 8N1 deserializer feeding a
// byte FIFO, read through a DATA/STATUS register pair. Defining
// UART_RX_PARITY_EN switches the frame format to 8E1.
//
// Read port handshake: rd is a single-cycle strobe with no back-pressure;
// the result appears on rd_data on the following cycle and is held until
// the next strobe. A DATA read pops the FIFO at that same edge.
module uart_rx_mmio
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rxd,
  input  logic        addr,
  input  logic        rd,
  output logic [15:0] rd_data,
  output logic        irq,
  output rx_state_t   rx_state
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx_mmio: CLK_FREQ/(BAUD*16) must be at least 1");
  end

  logic          sync_a;
  logic          rxd_s;
  logic [CW-1:0] div_cnt;
  logic          tick;

  rx_state_t     state, state_n;
  logic [3:0]    os_cnt, os_n;
  logic [2:0]    bit_idx, bit_n;
  logic [7:0]    shift, shift_n;
  logic          push, frame_evt;

  logic [7:0]    fifo_dout;
  logic [AW:0]   fifo_count;
  logic          fifo_full, fifo_empty;
  logic          pop, stat_rd, overrun_evt;
  logic          parity_err, frame_err, overrun;
  logic [15:0]   status_word;

  // Two-flop synchronizer for the asynchronous serial input (idles high).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b1;
      rxd_s  <= 1'b1;
    end else begin
      sync_a <= rxd;
      rxd_s  <= sync_a;
    end
  end

  assign tick = (div_cnt == CW'(DIV - 1));

  // Free-running oversample tick divider.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + CW'(1);
  end

  // Receive FSM state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      os_cnt  <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      state   <= state_n;
      os_cnt  <= os_n;
      bit_idx <= bit_n;
      shift   <= shift_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_evt;
`endif

  // Next-state and sample decisions; returns to IDLE straight after the
  // stop sample so a following start edge half a bit later is caught.
  always_comb begin
    state_n   = state;
    os_n      = os_cnt;
    bit_n     = bit_idx;
    shift_n   = shift;
    push      = 1'b0;
    frame_evt = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_evt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_n = START;
          os_n    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_cnt == MID_TICK) begin
            os_n    = '0;
            bit_n   = '0;
            state_n = rxd_s ? IDLE : DATA;
          end else begin
            os_n = os_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (os_cnt == LAST_TICK) begin
            os_n    = '0;
            shift_n = {rxd_s, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_idx + 3'd1;
            end
          end else begin
            os_n = os_cnt + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (os_cnt == LAST_TICK) begin
            os_n    = '0;
            par_evt = rxd_s ^ (^shift);
            state_n = STOP;
          end else begin
            os_n = os_cnt + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (os_cnt == LAST_TICK) begin
            os_n      = '0;
            state_n   = IDLE;
            push      = rxd_s;
            frame_evt = !rxd_s;
          end else begin
            os_n = os_cnt + 4'd1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_state = state;

  rx_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (shift),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign pop         = rd && (addr == ADDR_DATA) && !fifo_empty;
  assign stat_rd     = rd && (addr == ADDR_STATUS);
  assign overrun_evt = push && fifo_full && !pop;
  assign irq         = !fifo_empty;

  // Sticky error flags: cleared by a STATUS read unless a new event lands
  // in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= frame_evt   | (frame_err & ~stat_rd);
      overrun   <= overrun_evt | (overrun & ~stat_rd);
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity mismatch flag, same sticky/clear behaviour as the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) parity_err <= 1'b0;
    else        parity_err <= par_evt | (parity_err & ~stat_rd);
  end
`else
  assign parity_err = 1'b0;
`endif

  // STATUS register image.
  always_comb begin
    status_word                   = 16'h0000;
    status_word[STAT_PARITY_BIT]  = parity_err;
    status_word[STAT_FRAME_BIT]   = frame_err;
    status_word[STAT_OVERRUN_BIT] = overrun;
    status_word[4:0]              = 5'(fifo_count);
  end

  // Registered read data, held between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= 16'h0000;
    end else if (rd) begin
      if (addr == ADDR_STATUS) rd_data <= status_word;
      else if (!fifo_empty)    rd_data <= {8'h00, fifo_dout};
      else                     rd_data <= 16'h0000;
    end
  end

endmodule
